// File: rtl/dff_with_enable.sv
// Single-bit hold/load storage cell: gate-level 2:1 mux in front of a rising-edge
// flip-flop with asynchronous, active-high reset to a parameterised value.
module dff_with_enable #(
    parameter RESET = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic enable,
    output logic out
);

    // Any reset value other than a single 0 or 1 bit is an instantiation mistake.
    if ($bits(RESET) != 1) begin : gBadResetWidth
        $fatal(1, "dff_with_enable: RESET must be exactly 1 bit wide");
    end
    if (!(RESET == 1'b0 || RESET == 1'b1)) begin : gBadResetValue
        $fatal(1, "dff_with_enable: RESET must be 1'b0 or 1'b1");
    end

    localparam logic ResetValue = 1'(RESET);

    logic enableN;
    logic loadTerm;
    logic holdTerm;
    logic out_d;
    logic out_q;

    // Hold/load mux from primitive gates; X on enable with in != out yields X.
    assign enableN  = ~enable;
    assign loadTerm = in & enable;
    assign holdTerm = out_q & enableN;
    assign out_d    = loadTerm | holdTerm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= ResetValue;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_dff_with_enable.sv
// Self-checking bench for dff_with_enable: both reset polarities driven in parallel,
// a vector table, hand-written timing sequences and a randomized run against a model.
`timescale 1ps/1ps
module tb_dff_with_enable;

    logic clk = 1'b0;
    logic reset;
    logic in;
    logic enable;
    logic out0;
    logic out1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic reset;
        logic in;
        logic enable;
        logic exp0;
        logic exp1;
    } vec_t;

    vec_t vecs [11];

    logic model0;
    logic model1;
    logic rndReset;
    logic rndIn;
    logic rndEnable;

    dff_with_enable #(.RESET(1'b0)) dut0 (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .enable (enable),
        .out    (out0)
    );

    dff_with_enable #(.RESET(1'b1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .enable (enable),
        .out    (out1)
    );

    // 5000 ps clock period.
    always #2500 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic i, input logic e);
        reset  = r;
        in     = i;
        enable = e;
    endtask

    task automatic checkOutput(input string name, input logic exp0, input logic exp1);
        checks++;
        if (out0 !== exp0) begin
            errors++;
            $display("[TB] FAIL %s (RESET=0): out=%b expected %b at %0t", name, out0, exp0, $time);
        end
        checks++;
        if (out1 !== exp1) begin
            errors++;
            $display("[TB] FAIL %s (RESET=1): out=%b expected %b at %0t", name, out1, exp1, $time);
        end
    endtask

    initial begin
        // {reset, in, enable, expected out RESET=0, expected out RESET=1}
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset before any clock edge must already force the reset value.
        applyStimulus(1'b1, 1'b1, 1'b1);
        #1000;
        checkOutput("reset_state", 1'b0, 1'b1);

        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            applyStimulus(vecs[k].reset, vecs[k].in, vecs[k].enable);
            @(posedge clk);
            #100;
            checkOutput($sformatf("vec%0d", k), vecs[k].exp0, vecs[k].exp1);
        end

        // Reset asserted 1000 ps after an edge acts without waiting for a clock.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1000;
        reset = 1'b1;
        #10;
        checkOutput("async_mid_cycle", 1'b0, 1'b1);
        #1990;
        reset = 1'b0;
        #10;
        checkOutput("async_release", 1'b0, 1'b1);
        @(posedge clk);
        #100;
        checkOutput("async_hold", 1'b0, 1'b1);

        // Reset with enable across an edge, then released right at the edge.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #99;
        checkOutput("release_on_edge", 1'b0, 1'b1);
        @(posedge clk);
        #100;
        checkOutput("first_capture", 1'b1, 1'b1);

        // in changes 200 ps before the edge and must still be captured.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1);
        #2300;
        in = 1'b0;
        @(posedge clk);
        #100;
        checkOutput("setup_margin", 1'b0, 1'b0);

        // enable pulses mid-cycle but is 0 at the edge.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        #500;
        enable = 1'b1;
        #1000;
        enable = 1'b0;
        #200;
        enable = 1'b1;
        #200;
        enable = 1'b0;
        @(posedge clk);
        #100;
        checkOutput("enable_glitch", 1'b0, 1'b0);

        // Random run against the behavioural rule: reset wins, else enable loads, else hold.
        model0 = 1'b0;
        model1 = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rndReset  = ($urandom_range(0, 7) == 0);
            rndIn     = ($urandom_range(0, 1) == 1);
            rndEnable = ($urandom_range(0, 1) == 1);
            applyStimulus(rndReset, rndIn, rndEnable);
            if (rndReset) begin
                model0 = 1'b0;
                model1 = 1'b1;
                #100;
                checkOutput("rand_async", model0, model1);
            end
            @(posedge clk);
            #100;
            if (!rndReset && rndEnable) begin
                model0 = rndIn;
                model1 = rndIn;
            end
            checkOutput($sformatf("rand%0d", n), model0, model1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
